// File: rtl/axi4l_times_table_reader.sv
// ============================================================================
// axi4l_times_table_reader : one-entry-buffered AXI4-Lite read sequencer for
// the 8x8 times-table BRAM. Rev 1.0
// ============================================================================
`default_nettype none

module axi4l_times_table_reader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        a,
  input  logic [2:0]        b,
  output logic              done,
  output logic [5:0]        result,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  output logic              m_axi_bready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               pend_full_q, pend_full_d;
  logic [2:0]         pend_a_q, pend_a_d;
  logic [2:0]         pend_b_q, pend_b_d;
  logic               req_ready_q, req_ready_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               done_q, done_d;
  logic [5:0]         result_q, result_d;
  logic               err_q, err_d;
  logic               accept;
  logic               launch_direct;
  logic               unused_rdata;

  // Word address of table entry (x,y): ((x*8)+y)*4.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [2:0] x, input logic [2:0] y);
    return {{(ADDR_W-8){1'b0}}, x, y, 2'b00};
  endfunction

  assign accept        = req_valid & req_ready_q;
  // An idle sequencer with nothing buffered issues the new request straight away.
  assign launch_direct = (state_q == IDLE) & ~pend_full_q & accept;

  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    done_d      = 1'b0;
    result_d    = result_q;
    err_d       = err_q;

    if (accept && !launch_direct) begin
      pend_full_d = 1'b1;
      pend_a_d    = a;
      pend_b_d    = b;
    end

    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          araddr_d    = word_addr(pend_a_q, pend_b_q);
          arvalid_d   = 1'b1;
          state_d     = AR;
          pend_full_d = accept;
        end else if (launch_direct) begin
          araddr_d  = word_addr(a, b);
          arvalid_d = 1'b1;
          state_d   = AR;
        end
      end
      AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (m_axi_rvalid) begin
          result_d = m_axi_rdata[5:0];
          err_d    = (m_axi_rresp != 2'b00);
          done_d   = 1'b1;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase

    req_ready_d = ~pend_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      pend_a_q    <= 3'd0;
      pend_b_q    <= 3'd0;
      req_ready_q <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 6'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      req_ready_q <= req_ready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign done          = done_q;
  assign result        = result_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE) | pend_full_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  // Only the product bits of the read word are meaningful.
  assign unused_rdata  = ^m_axi_rdata[DATA_W-1:6];

  assign m_axi_awaddr  = '0;
  assign m_axi_awvalid = 1'b0;
  assign m_axi_wdata   = '0;
  assign m_axi_wstrb   = 4'b0000;
  assign m_axi_wvalid  = 1'b0;
  assign m_axi_bready  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_axi4l_times_table_reader.sv
// ============================================================================
// tb_axi4l_times_table_reader : directed bench with a transaction-level model
// and a behavioural times-table AXI4-Lite slave. Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi4l_times_table_reader;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        a;
  logic [2:0]        b;
  logic              done;
  logic [5:0]        result;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              bready;

  always #5 clk = ~clk;

  axi4l_times_table_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .a             (a),
    .b             (b),
    .done          (done),
    .result        (result),
    .err           (err),
    .busy          (busy),
    .m_axi_araddr  (araddr),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_bready  (bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: lookups waiting for their address beat, lookups waiting for data.
  logic [5:0]  issue_q[$];
  logic [5:0]  resp_q[$];
  logic [5:0]  got_q[$];
  bit          m_inf, m_pend;
  bit          exp_done;
  logic [5:0]  exp_result;
  logic        exp_err;
  int          edge_cnt = 0, acc_cnt = 0, done_cnt = 0, acc_edge = 0, done_edge = 0;
  logic [31:0] last_araddr = 0;
  bit          slv_have_ar;
  logic [31:0] slv_addr;
  bit          prev_ar_wait;
  logic [31:0] prev_addr;

  // Slave behaviour knobs.
  int          s_ar_wait = 0;
  int          s_cnt = 0;
  logic [1:0]  s_resp = 2'b00;
  bit          s_stray = 0;

  // Monitor / model update on every active edge using pre-edge values.
  always @(posedge clk) begin
    bit         acc, arhs, rhs, oi, op;
    logic [5:0] e;
    edge_cnt++;
    if (!rst_n) begin
      issue_q.delete();
      resp_q.delete();
      m_inf        = 0;
      m_pend       = 0;
      exp_done     = 0;
      exp_result   = 6'd0;
      exp_err      = 1'b0;
      slv_have_ar  = 0;
      prev_ar_wait = 0;
    end else begin
      acc  = req_valid && req_ready;
      arhs = arvalid && arready;
      rhs  = rvalid && rready;
      if (prev_ar_wait) begin
        check("ar_hold_valid", {31'd0, arvalid}, 32'd1);
        check("ar_hold_addr", araddr, prev_addr);
      end
      prev_ar_wait = arvalid && !arready;
      prev_addr    = araddr;
      if (arhs) begin
        if (issue_q.size() == 0) check("spurious_ar", 32'd1, 32'd0);
        else begin
          e = issue_q.pop_front();
          check("araddr", araddr, (e[5:3] * 8 + e[2:0]) * 4);
          resp_q.push_back(e);
        end
        last_araddr = araddr;
        slv_have_ar = 1;
        slv_addr    = araddr;
      end
      exp_done = 0;
      if (rhs) begin
        if (resp_q.size() == 0) check("spurious_r", 32'd1, 32'd0);
        else begin
          e          = resp_q.pop_front();
          exp_done   = 1;
          exp_result = e[5:3] * e[2:0];
          exp_err    = (rresp != 2'b00);
          done_cnt++;
          done_edge  = edge_cnt;
        end
        slv_have_ar = 0;
      end
      if (acc) begin
        issue_q.push_back({a, b});
        acc_cnt++;
        acc_edge = edge_cnt;
      end
      // One lookup in flight plus at most one buffered.
      oi = m_inf;
      op = m_pend;
      if (!oi) begin
        if (op) begin
          m_inf  = 1;
          m_pend = acc;
        end else if (acc) m_inf = 1;
      end else begin
        if (acc) m_pend = 1;
        if (rhs) m_inf = 0;
      end
    end
  end

  // Behavioural times-table slave; data is derived from the address it receives.
  always @(negedge clk) begin
    logic [31:0] rnd;
    logic [5:0]  idx;
    logic [5:0]  prod;
    if (!rst_n) begin
      arready = 0;
      rvalid  = 0;
      rdata   = '0;
      rresp   = 2'b00;
      s_cnt   = 0;
    end else begin
      rnd = $urandom();
      if (slv_have_ar) begin
        idx    = slv_addr[7:2];
        prod   = idx[5:3] * idx[2:0];
        rdata  = {rnd[31:6], prod};
        rresp  = s_resp;
        rvalid = 1;
      end else begin
        rdata  = rnd;
        rresp  = 2'b11;
        rvalid = s_stray;
      end
      if (arvalid && !slv_have_ar) begin
        if (s_cnt >= s_ar_wait) arready = 1;
        else begin
          arready = 0;
          s_cnt++;
        end
      end else begin
        arready = 0;
        s_cnt   = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("rst_arvalid", {31'd0, arvalid}, 32'd0);
      check("rst_rready", {31'd0, rready}, 32'd0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", {26'd0, result}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    end else begin
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("result", {26'd0, result}, {26'd0, exp_result});
      check("err", {31'd0, err}, {31'd0, exp_err});
      check("req_ready", {31'd0, req_ready}, {31'd0, !m_pend});
      check("busy", {31'd0, busy}, {31'd0, (m_inf || m_pend)});
      if (done) got_q.push_back(result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 20) begin
      tick();
      n++;
    end
    check("accept_timeout", acc_cnt, target);
  endtask

  task automatic lookup(input logic [2:0] xa, input logic [2:0] xb, input int lat_exp,
                        input logic [5:0] res_exp, input logic err_exp,
                        input logic [31:0] addr_exp, input string nm);
    int c0, d0, n;
    c0 = acc_cnt;
    d0 = done_cnt;
    req_valid = 1;
    a = xa;
    b = xb;
    wait_acc(c0 + 1);
    req_valid = 0;
    n = 0;
    while (done_cnt == d0 && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_done"}, done_cnt - d0, 32'd1);
    check({nm, "_result"}, {26'd0, result}, {26'd0, res_exp});
    check({nm, "_err"}, {31'd0, err}, {31'd0, err_exp});
    check({nm, "_araddr"}, last_araddr, addr_exp);
    if (lat_exp > 0) check({nm, "_latency"}, done_edge - acc_edge + 1, lat_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int c0, d0, n;
    rst_n     = 1;
    req_valid = 0;
    a         = 3'd0;
    b         = 3'd0;
    arready   = 0;
    rvalid    = 0;
    rdata     = '0;
    rresp     = 2'b00;
    #1 rst_n  = 0;
    repeat (3) tick();
    @(negedge clk) rst_n = 1;
    tick();
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);
    check("tie_awvalid", {31'd0, awvalid}, 32'd0);
    check("tie_wvalid", {31'd0, wvalid}, 32'd0);
    check("tie_bready", {31'd0, bready}, 32'd0);
    check("tie_wstrb", {28'd0, wstrb}, 32'd0);
    check("tie_awaddr", awaddr, 32'd0);
    check("tie_wdata", wdata, 32'd0);

    // Basic lookup, zero-wait slave.
    lookup(3'd3, 3'd5, 3, 6'd15, 1'b0, 32'h74, "t1");

    // Address extremes, with stray rvalid while not in the data phase.
    s_stray = 1;
    lookup(3'd7, 3'd7, 3, 6'd49, 1'b0, 32'hFC, "t2_max");
    lookup(3'd0, 3'd0, 3, 6'd0, 1'b0, 32'h00, "t2_min");
    s_stray = 0;

    // Address channel back-pressure for 5 cycles.
    s_ar_wait = 5;
    lookup(3'd6, 3'd3, 8, 6'd18, 1'b0, 32'hCC, "t3");
    s_ar_wait = 0;

    // Back-to-back with req_valid held.
    c0 = acc_cnt;
    d0 = done_cnt;
    got_q.delete();
    req_valid = 1;
    a = 3'd2;
    b = 3'd3;
    wait_acc(c0 + 1);
    a = 3'd4;
    b = 3'd6;
    wait_acc(c0 + 2);
    check("t4_ready_low", {31'd0, req_ready}, 32'd0);
    req_valid = 0;
    n = 0;
    while (done_cnt < d0 + 2 && n < 50) begin
      tick();
      n++;
    end
    tick();
    check("t4_done_count", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      check("t4_first", {26'd0, got_q[0]}, 32'd6);
      check("t4_second", {26'd0, got_q[1]}, 32'd24);
    end

    // Error response, then cleared by a good lookup.
    s_resp = 2'b10;
    lookup(3'd1, 3'd1, 3, 6'd1, 1'b1, 32'h24, "t5_slverr");
    s_resp = 2'b00;
    lookup(3'd2, 3'd2, 3, 6'd4, 1'b0, 32'h48, "t5_ok");

    // Reset while stalled in the address phase with the buffer full.
    s_ar_wait = 1000;
    c0 = acc_cnt;
    d0 = done_cnt;
    req_valid = 1;
    a = 3'd5;
    b = 3'd2;
    wait_acc(c0 + 1);
    a = 3'd3;
    b = 3'd3;
    wait_acc(c0 + 2);
    req_valid = 0;
    tick();
    tick();
    check("t6_arvalid_before", {31'd0, arvalid}, 32'd1);
    check("t6_ready_before", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("t6_arvalid_in_rst", {31'd0, arvalid}, 32'd0);
    check("t6_ready_in_rst", {31'd0, req_ready}, 32'd0);
    tick();
    tick();
    s_ar_wait = 0;
    @(negedge clk) rst_n = 1;
    repeat (4) tick();
    check("t6_no_done", done_cnt - d0, 32'd0);
    check("t6_idle", {31'd0, busy}, 32'd0);
    check("t6_ready_after", {31'd0, req_ready}, 32'd1);
    lookup(3'd5, 3'd6, 3, 6'd30, 1'b0, 32'hB8, "t6_fresh");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
